usb_uart_bridge: RTL and testbench
==================================

# usb_uart_bridge

Byte-stream bridge between the `usb_uart` streaming pipeline (`uart_in_*` / `uart_out_*`) and the USB CDC bulk-endpoint side of the protocol engine, running in the 48 MHz PLL domain.

- IN direction (device to host): an IN FIFO with speculative read and commit/rollback, so NAK'd or timed-out packets are retransmitted.
- OUT direction (host to device): an OUT FIFO with speculative write and commit/rollback, so CRC-failed packets are discarded.

## Interface
Parameters:
- `DEPTH`, 128: bytes per FIFO; power of two, at least `2*MAX_PKT`.
- `MAX_PKT`, 64: maximum bulk packet size in bytes.

Ports:
- `clk_48mhz`  in  1  Clock.
- `reset`  in  1  Reset. One clock; reset is synchronous and active-high.
- `uart_in_data`  in  8  Byte toward the host.
- `uart_in_valid`  in  1  `uart_in_data` is valid.
- `uart_in_ready`  out  1  IN FIFO can accept a byte.
- `uart_out_data`  out  8  Byte from the host.
- `uart_out_valid`  out  1  `uart_out_data` is valid.
- `uart_out_ready`  in  1  Consumer takes the byte.
- `ep_in_data`  out  8  Byte at the speculative IN read pointer.
- `ep_in_avail`  out  7  min(unread bytes, `MAX_PKT`).
- `ep_in_get`  in  1  Pop one byte speculatively.
- `ep_in_commit`  in  1  Host ACK received; free all speculatively read bytes.
- `ep_in_rollback`  in  1  No ACK; rewind the read pointer to the last commit.
- `ep_out_data`  in  8  Received payload byte.
- `ep_out_put`  in  1  Write one byte speculatively.
- `ep_out_commit`  in  1  Packet CRC good; publish the speculatively written bytes.
- `ep_out_rollback`  in  1  Packet bad; discard the speculatively written bytes.
- `ep_out_can_accept`  out  1  Free space is at least `MAX_PKT`; the engine NAKs when this is low.

## Operation
Pointers:
- Each FIFO keeps a write pointer, a speculative pointer and a committed pointer.
- Pointers are log2(`DEPTH`)+1 bits wide and wrap modulo 2·`DEPTH`.
- Full means (write − committed read) == `DEPTH`. Empty means the pointers are equal.

IN FIFO:
- A uart_in handshake (`uart_in_valid` & `uart_in_ready`) writes the byte and increments `wr`.
- `uart_in_ready` = !full, where full is measured against `rd_commit`.
- `ep_in_get` with `ep_in_avail` == 0 is ignored.
- `ep_in_commit` sets `rd_commit` to `rd_spec`, including any get in the same cycle.
- `ep_in_rollback` sets `rd_spec` to `rd_commit`. A get in the same cycle is ignored.

OUT FIFO:
- `ep_out_put` writes at `wr_spec`. It is ignored if (`wr_spec` − `rd`) == `DEPTH`.
- `ep_out_commit` sets `wr_commit` to `wr_spec`, including a put in the same cycle.
- `ep_out_rollback` sets `wr_spec` to `wr_commit`. A put in the same cycle is ignored.
- `uart_out_valid` = (`wr_commit` != `rd`). Consumer handshake increments `rd`.

Priority and width rules:
- Commit and rollback asserted together: commit wins in both FIFOs.
- All pointer arithmetic is unsigned modulo 2·`DEPTH`. `ep_in_avail` saturates at `MAX_PKT`.

## Timing
- Reset values: `uart_in_ready`=0, `uart_out_valid`=0, `ep_in_avail`=0, `ep_out_can_accept`=0, `uart_out_data`=0, `ep_in_data`=0, all pointers 0.
- `uart_in_ready` and `ep_out_can_accept` rise the first cycle after reset deasserts.
- Reset mid-packet discards all FIFO contents, committed or not.
- A uart_in byte accepted at edge N is visible in `ep_in_avail` and `ep_in_data` after edge N+1.
- `ep_in_data` is first-word-fall-through. It shows the next byte the cycle after `ep_in_get`.
- A committed OUT packet raises `uart_out_valid` the cycle after the commit edge.
- `uart_out_data` updates the cycle after each handshake.
- Full throughput is one byte per clock per direction, with both directions concurrent.

## Configuration
- `USB_UART_BRIDGE_LOOPBACK_EN` defined:
  - Committed OUT bytes feed the IN FIFO internally, one per cycle, whenever the IN FIFO is not full.
  - `uart_in_ready` is held 0, `uart_out_valid` is held 0, and `uart_in_*` is ignored.
- Not defined: normal bridging as described above.

## Test plan
- Reset, then stream "Hello World!\r\n" (14 bytes) on uart_in:
  - `ep_in_avail` reaches 14.
  - 14 gets return 0x48 … 0x0A in order.
  - Commit, then `ep_in_avail`=0.
- Get 5 bytes, then rollback: `ep_in_avail` returns to 14 and `ep_in_data`=0x48. Get 14 and commit: the FIFO is empty.
- Write 128 bytes with no commit:
  - `uart_in_ready` falls after byte 128, and byte 129 is not accepted.
  - 64 gets plus commit raise `uart_in_ready` the next cycle.
- Put 10 bytes, then rollback: `uart_out_valid` stays 0. Put 0x01..0x03 and commit: uart_out delivers 0x01, 0x02, 0x03.
- Commit and rollback in the same cycle after 4 puts: the 4 bytes appear on uart_out.
- Loopback build: put 0x41 and commit; within 3 cycles `ep_in_avail`=1 and `ep_in_data`=0x41.

Source files
------------

// File: rtl/usb_uart_bridge.sv
// Byte bridge between the usb_uart stream and the CDC bulk endpoints, using speculative FIFOs.
// Define USB_UART_BRIDGE_LOOPBACK_EN to route committed OUT bytes back into the IN FIFO.
module usb_uart_bridge #(
    parameter int DEPTH   = 128,
    parameter int MAX_PKT = 64
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] uart_in_data,
    input  logic       uart_in_valid,
    output logic       uart_in_ready,
    output logic [7:0] uart_out_data,
    output logic       uart_out_valid,
    input  logic       uart_out_ready,
    output logic [7:0] ep_in_data,
    output logic [6:0] ep_in_avail,
    input  logic       ep_in_get,
    input  logic       ep_in_commit,
    input  logic       ep_in_rollback,
    input  logic [7:0] ep_out_data,
    input  logic       ep_out_put,
    input  logic       ep_out_commit,
    input  logic       ep_out_rollback,
    output logic       ep_out_can_accept
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [7:0] imem [DEPTH];
    logic [7:0] omem [DEPTH];

    logic alive_q;
    ptr_t iwr_q, iwr_d, irs_q, irs_d, irc_q, irc_d;
    ptr_t owr_q, owr_d, owc_q, owc_d, ord_q, ord_d;
    logic [6:0] avail_q, avail_d;
    logic [7:0] idata_q, idata_d;

    logic       in_full, out_full, out_has;
    logic       in_wr, out_take, get_en, put_en;
    logic [7:0] in_wdata;
    ptr_t       in_diff;

    assign in_full  = (iwr_q - irc_q) == ptr_t'(DEPTH);
    assign out_full = (owr_q - ord_q) == ptr_t'(DEPTH);
    assign out_has  = owc_q != ord_q;

`ifdef USB_UART_BRIDGE_LOOPBACK_EN
    logic unused_lb;
    assign unused_lb      = ^{uart_in_data, uart_in_valid, uart_out_ready};
    assign uart_in_ready  = 1'b0;
    assign uart_out_valid = 1'b0;
    assign in_wr          = out_has & ~in_full;
    assign in_wdata       = omem[ord_q[AW-1:0]];
    assign out_take       = in_wr;
`else
    assign uart_in_ready  = alive_q & ~in_full;
    assign uart_out_valid = out_has;
    assign in_wr          = uart_in_valid & uart_in_ready;
    assign in_wdata       = uart_in_data;
    assign out_take       = out_has & uart_out_ready;
`endif

    assign uart_out_data     = out_has ? omem[ord_q[AW-1:0]] : 8'h00;
    assign ep_in_data        = idata_q;
    assign ep_in_avail       = avail_q;
    assign ep_out_can_accept = alive_q &
        ((owr_q - ord_q) <= ptr_t'(DEPTH - MAX_PKT));

    always_comb begin
        get_en = ep_in_get & (avail_q != 7'd0) &
                 (ep_in_commit | ~ep_in_rollback);
        iwr_d  = iwr_q + ptr_t'(in_wr);
        irs_d  = irs_q + ptr_t'(get_en);
        irc_d  = irc_q;
        if (ep_in_commit)
            irc_d = irs_d;
        else if (ep_in_rollback)
            irs_d = irc_q;

        // Old wr pointer here gives the one-cycle write-to-visible latency
        in_diff = iwr_q - irs_d;
        avail_d = (in_diff > ptr_t'(MAX_PKT)) ? 7'(MAX_PKT) : in_diff[6:0];
        idata_d = (in_diff != '0) ? imem[irs_d[AW-1:0]] : 8'h00;

        put_en = ep_out_put & ~out_full &
                 (ep_out_commit | ~ep_out_rollback);
        owr_d  = owr_q + ptr_t'(put_en);
        owc_d  = owc_q;
        if (ep_out_commit)
            owc_d = owr_d;
        else if (ep_out_rollback)
            owr_d = owc_q;
        ord_d = ord_q + ptr_t'(out_take);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            alive_q <= 1'b0;
            iwr_q   <= '0;
            irs_q   <= '0;
            irc_q   <= '0;
            owr_q   <= '0;
            owc_q   <= '0;
            ord_q   <= '0;
            avail_q <= '0;
            idata_q <= '0;
        end else begin
            alive_q <= 1'b1;
            iwr_q   <= iwr_d;
            irs_q   <= irs_d;
            irc_q   <= irc_d;
            owr_q   <= owr_d;
            owc_q   <= owc_d;
            ord_q   <= ord_d;
            avail_q <= avail_d;
            idata_q <= idata_d;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (in_wr)
            imem[iwr_q[AW-1:0]] <= in_wdata;
        if (put_en)
            omem[owr_q[AW-1:0]] <= ep_out_data;
    end
endmodule

// File: tb/tb_usb_uart_bridge.sv
// Scoreboard bench for usb_uart_bridge: IN stream/rollback/full, OUT rollback/commit.
module tb_usb_uart_bridge;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] uart_in_data = '0;
    logic       uart_in_valid = 1'b0;
    logic       uart_in_ready;
    logic [7:0] uart_out_data;
    logic       uart_out_valid;
    logic       uart_out_ready = 1'b0;
    logic [7:0] ep_in_data;
    logic [6:0] ep_in_avail;
    logic       ep_in_get = 1'b0;
    logic       ep_in_commit = 1'b0;
    logic       ep_in_rollback = 1'b0;
    logic [7:0] ep_out_data = '0;
    logic       ep_out_put = 1'b0;
    logic       ep_out_commit = 1'b0;
    logic       ep_out_rollback = 1'b0;
    logic       ep_out_can_accept;

    int total = 0;
    int bad = 0;

    logic [7:0] inq[$];
    logic [7:0] spec[$];
    logic [7:0] pend[$];
    logic [7:0] outq[$];

    logic [7:0] hello [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
        8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    usb_uart_bridge dut (
        .clk_48mhz(clk), .reset(reset),
        .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .uart_out_data(uart_out_data), .uart_out_valid(uart_out_valid),
        .uart_out_ready(uart_out_ready),
        .ep_in_data(ep_in_data), .ep_in_avail(ep_in_avail),
        .ep_in_get(ep_in_get), .ep_in_commit(ep_in_commit),
        .ep_in_rollback(ep_in_rollback),
        .ep_out_data(ep_out_data), .ep_out_put(ep_out_put),
        .ep_out_commit(ep_out_commit), .ep_out_rollback(ep_out_rollback),
        .ep_out_can_accept(ep_out_can_accept)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_hello();
        for (int i = 0; i < 14; i++) begin
            uart_in_valid = 1'b1;
            uart_in_data  = hello[i];
            inq.push_back(hello[i]);
            tick();
        end
        uart_in_valid = 1'b0;
    endtask

    task automatic get_n(input int n);
        for (int i = 0; i < n; i++) begin
            chk("in_data", ep_in_data, inq[0]);
            ep_in_get = 1'b1;
            tick();
            spec.push_back(inq.pop_front());
        end
        ep_in_get = 1'b0;
    endtask

    task automatic in_commit();
        ep_in_commit = 1'b1;
        tick();
        ep_in_commit = 1'b0;
        spec.delete();
    endtask

    task automatic in_rollback();
        for (int i = spec.size() - 1; i >= 0; i--)
            inq.push_front(spec[i]);
        spec.delete();
        ep_in_rollback = 1'b1;
        tick();
        ep_in_rollback = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        ep_out_put  = 1'b1;
        ep_out_data = b;
        pend.push_back(b);
        tick();
        ep_out_put = 1'b0;
    endtask

    task automatic out_end(input logic c, input logic r);
        if (c) begin
            foreach (pend[i]) outq.push_back(pend[i]);
        end
        pend.delete();
        ep_out_commit   = c;
        ep_out_rollback = r;
        tick();
        ep_out_commit   = 1'b0;
        ep_out_rollback = 1'b0;
    endtask

    task automatic drain_out();
        uart_out_ready = 1'b1;
        for (int c = 0; c < 40 && outq.size() > 0; c++) begin
            if (uart_out_valid)
                chk("out_data", uart_out_data, outq.pop_front());
            tick();
        end
        uart_out_ready = 1'b0;
        chk("out_left", outq.size(), 0);
        chk("out_valid_idle", uart_out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_in_ready", uart_in_ready, 1'b0);
        chk("rst_out_valid", uart_out_valid, 1'b0);
        chk("rst_avail", ep_in_avail, 7'd0);
        chk("rst_can_accept", ep_out_can_accept, 1'b0);
        chk("rst_out_data", uart_out_data, 8'h00);
        chk("rst_in_data", ep_in_data, 8'h00);
        reset = 1'b0;
        tick();
        chk("in_ready_up", uart_in_ready, 1'b0
`ifndef USB_UART_BRIDGE_LOOPBACK_EN
            | 1'b1
`endif
        );
        chk("can_accept_up", ep_out_can_accept, 1'b1);

`ifdef USB_UART_BRIDGE_LOOPBACK_EN
        put(8'h41);
        out_end(1'b1, 1'b0);
        for (int c = 0; c < 3 && ep_in_avail == 7'd0; c++)
            tick();
        chk("lb_avail", ep_in_avail, 7'd1);
        chk("lb_data", ep_in_data, 8'h41);
        chk("lb_out_valid", uart_out_valid, 1'b0);
`else
        send_hello();
        chk("avail_lag", ep_in_avail, 7'd13);
        tick();
        chk("avail_14", ep_in_avail, 7'd14);
        get_n(14);
        in_commit();
        chk("avail_commit", ep_in_avail, 7'd0);

        send_hello();
        tick();
        get_n(5);
        chk("avail_after5", ep_in_avail, 7'd9);
        in_rollback();
        chk("avail_rollback", ep_in_avail, 7'd14);
        chk("data_rollback", ep_in_data, 8'h48);
        get_n(14);
        in_commit();
        chk("avail_empty", ep_in_avail, 7'd0);

        for (int i = 0; i < 128; i++) begin
            uart_in_valid = 1'b1;
            uart_in_data  = 8'(i) ^ 8'h5A;
            inq.push_back(8'(i) ^ 8'h5A);
            tick();
        end
        chk("full_ready", uart_in_ready, 1'b0);
        uart_in_data = 8'hEE;
        tick();
        uart_in_valid = 1'b0;
        chk("avail_sat", ep_in_avail, 7'd64);
        get_n(64);
        chk("full_hold", uart_in_ready, 1'b0);
        in_commit();
        chk("ready_after_commit", uart_in_ready, 1'b1);
        get_n(64);
        in_commit();
        chk("no_byte129", ep_in_avail, 7'd0);

        for (int i = 0; i < 64; i++)
            put(8'(i));
        chk("can_accept_64", ep_out_can_accept, 1'b1);
        put(8'hFF);
        chk("can_accept_65", ep_out_can_accept, 1'b0);
        out_end(1'b0, 1'b1);
        chk("can_accept_rb", ep_out_can_accept, 1'b1);

        for (int i = 0; i < 10; i++)
            put(8'h80 + 8'(i));
        chk("spec_not_valid", uart_out_valid, 1'b0);
        out_end(1'b0, 1'b1);
        tick();
        chk("rb_not_valid", uart_out_valid, 1'b0);
        put(8'h01);
        put(8'h02);
        put(8'h03);
        out_end(1'b1, 1'b0);
        chk("commit_valid", uart_out_valid, 1'b1);
        drain_out();

        for (int i = 0; i < 4; i++)
            put(8'hA0 + 8'(i));
        out_end(1'b1, 1'b1);
        drain_out();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
